// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// addsub_pkg : shared types, constants and helpers for pipelined_addsub
// Revision   : 1.0
// ============================================================================
package addsub_pkg;

  localparam int MAX_WIDTH = 128;
  localparam logic [MAX_WIDTH-1:0] ONE_W = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zr;
    logic ng;
  } addsub_flags_t;

  function automatic int calc_stages(input int width, input int seg);
    return (seg < 1) ? 1 : width / seg;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
    return ONE_W << (width - 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
    return signed_min(width) - ONE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// addsub_slice : SEG-bit combinational adder slice with carry in/out
// Revision     : 1.0
// ============================================================================
module addsub_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// pipelined_addsub : WIDTH-bit add/sub, one SEG-bit slice per stage, valid/ready
// Optional macro ADDSUB_SAT_EN : signed saturation of the result on overflow
// Revision         : 1.0
// ============================================================================
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zr,
  output logic             ng
);

  localparam int STAGES = calc_stages(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;

  if ((SEG < 1) || ((WIDTH % ((SEG < 1) ? 1 : SEG)) != 0)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a positive multiple of SEG");
  end

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(signed_max(WIDTH));
`endif

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             valid_d [STAGES];
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] sum_d, sum_q;
  addsub_flags_t    flags_d, flags_q;

  // Everything presented to stage k's adder, whether from the ports or stage k-1
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_bp  [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic             st_c   [STAGES];
  logic             st_v   [STAGES];
  logic [SEG-1:0]   slice_sum  [STAGES];
  logic             slice_cout [STAGES];

  assign en        = !valid_q[LAST] || out_ready;
  assign in_ready  = en;
  assign b_eff     = sub ? ~b : b;
  assign c0        = sub | cin;
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zr        = flags_q.zr;
  assign ng        = flags_q.ng;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    addsub_slice #(.SEG(SEG)) u_slice (
      .a    (st_a[k][k*SEG +: SEG]),
      .b    (st_bp[k][k*SEG +: SEG]),
      .cin  (st_c[k]),
      .sum  (slice_sum[k]),
      .cout (slice_cout[k])
    );
  end

  if (STAGES > 1) begin : g_pipe
    localparam int MID = STAGES - 1;

    logic [WIDTH-1:0] a_d [MID], a_q [MID];
    logic [WIDTH-1:0] bp_d [MID], bp_q [MID];
    logic [WIDTH-1:0] psum_d [MID], psum_q [MID];
    logic             carry_d [MID], carry_q [MID];

    always_comb begin
      st_v[0]   = in_valid;
      st_a[0]   = a;
      st_bp[0]  = b_eff;
      st_c[0]   = c0;
      st_sum[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
        st_v[k]   = valid_q[k-1];
        st_a[k]   = a_q[k-1];
        st_bp[k]  = bp_q[k-1];
        st_c[k]   = carry_q[k-1];
        st_sum[k] = psum_q[k-1];
      end
    end

    always_comb begin
      for (int k = 0; k < MID; k++) begin
        a_d[k]                    = st_a[k];
        bp_d[k]                   = st_bp[k];
        carry_d[k]                = slice_cout[k];
        psum_d[k]                 = st_sum[k];
        psum_d[k][k*SEG +: SEG]   = slice_sum[k];
      end
    end

    // Operand/partial-sum registers only load on live operations
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < MID; k++) begin
          a_q[k]     <= '0;
          bp_q[k]    <= '0;
          psum_q[k]  <= '0;
          carry_q[k] <= 1'b0;
        end
      end else if (en) begin
        for (int k = 0; k < MID; k++) begin
          if (valid_d[k]) begin
            a_q[k]     <= a_d[k];
            bp_q[k]    <= bp_d[k];
            psum_q[k]  <= psum_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
    end
  end else begin : g_single
    always_comb begin
      st_v[0]   = in_valid;
      st_a[0]   = a;
      st_bp[0]  = b_eff;
      st_c[0]   = c0;
      st_sum[0] = '0;
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = st_v[k];
    end
    sum_d                  = st_sum[LAST];
    sum_d[LAST*SEG +: SEG] = slice_sum[LAST];
    flags_d.cout = slice_cout[LAST];
    flags_d.ovf  = (st_a[LAST][WIDTH-1] == st_bp[LAST][WIDTH-1]) &&
                   (sum_d[WIDTH-1] != st_a[LAST][WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    if (flags_d.ovf) begin
      sum_d = st_a[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
    flags_d.zr = (sum_d == '0);
    flags_d.ng = sum_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
      end
      sum_q   <= '0;
      flags_q <= '0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
      end
      if (valid_d[LAST]) begin
        sum_q   <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// tb_pipelined_addsub : directed table, stall/reset sequences, random sweeps
// Revision            : 1.0
// ============================================================================
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zr, ng;
  logic [15:0] a, b, sum;

  logic        s_in_valid, s_out_ready, s_sub, s_cin;
  logic [31:0] w_a, w_b, w_sum;
  logic        w_in_ready, w_out_valid, w_cout, w_ovf, w_zr, w_ng;
  logic [15:0] n_a, n_b, n_sum;
  logic        n_in_ready, n_out_valid, n_cout, n_ovf, n_zr, n_ng;

  pipelined_addsub #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zr(zr), .ng(ng)
  );

  pipelined_addsub #(.WIDTH(32), .SEG(8)) dut_w (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .sub(s_sub), .cin(s_cin), .out_valid(w_out_valid), .out_ready(s_out_ready),
    .sum(w_sum), .cout(w_cout), .ovf(w_ovf), .zr(w_zr), .ng(w_ng)
  );

  pipelined_addsub #(.WIDTH(16), .SEG(16)) dut_n (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .sub(s_sub), .cin(s_cin), .out_valid(n_out_valid), .out_ready(s_out_ready),
    .sum(n_sum), .cout(n_cout), .ovf(n_ovf), .zr(n_zr), .ng(n_ng)
  );

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a, b;
    logic        sub, cin;
    logic [15:0] sum;
    logic        cout, ovf, zr, ng;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout, ovf, zr, ng;
  } res_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: exact signed/unsigned arithmetic, then wrap or saturate
  function automatic res_t ref_model(input int w, input logic [63:0] ra, input logic [63:0] rb,
                                     input logic rs, input logic rc);
    res_t        r;
    longint      sa, sb, ex, smax, smin;
    logic [63:0] mask;
    logic [64:0] u;
    mask = (64'd1 << w) - 64'd1;
    sa   = longint'(ra << (64 - w)) >>> (64 - w);
    sb   = longint'(rb << (64 - w)) >>> (64 - w);
    smax = (longint'(1) <<< (w - 1)) - 1;
    smin = -smax - 1;
    ex   = rs ? (sa - sb) : (sa + sb + longint'(rc));
    r.ovf = (ex > smax) || (ex < smin);
    r.sum = ex[63:0] & mask;
    if (rs) begin
      r.cout = (ra & mask) >= (rb & mask);
    end else begin
      u      = {1'b0, ra & mask} + {1'b0, rb & mask} + {64'd0, rc};
      r.cout = u[w];
    end
    if (SAT && r.ovf) r.sum = (ex > smax) ? smax[63:0] : (smin[63:0] & mask);
    r.zr = (r.sum == 64'd0);
    r.ng = r.sum[w-1];
    return r;
  endfunction

  task automatic do_op(input vec_t v, output int lat);
    @(posedge clk); #1;
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic stall_test();
    res_t        q[$];
    res_t        e;
    logic [20:0] prev;
    int          sent = 0;
    int          got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 6 && c <= 9);
      in_valid  = (sent < 8);
      a   = (c >= 6 && c <= 9) ? 16'hDEAD : 16'(sent * 16'h1357 + 16'h7000);
      b   = 16'(16'h0F0F ^ sent);
      sub = sent[0];
      cin = sent[1];
      @(negedge clk);
      if (c >= 6 && c <= 9) begin
        chk($sformatf("stall_in_ready_c%0d", c), {63'd0, in_ready}, 64'd0);
        if (c > 6) chk($sformatf("stall_stable_c%0d", c), {43'd0, out_valid, sum, cout, ovf, zr, ng}, {43'd0, prev});
      end
      prev = {out_valid, sum, cout, ovf, zr, ng};
      if (in_valid && in_ready) begin
        q.push_back(ref_model(16, {48'd0, a}, {48'd0, b}, sub, cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_spurious: got an unexpected result 0x%0h, expected none", sum);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream_res%0d", got), {44'd0, sum, cout, ovf, zr, ng},
              {44'd0, e.sum[15:0], e.cout, e.ovf, e.zr, e.ng});
          got++;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", 64'(got), 64'd8);
  endtask

  task automatic reset_test();
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
      a = 16'(16'h0101 * (i + 1)); b = 16'h0001;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("reset_async", {43'd0, out_valid, sum, cout, ovf, zr, ng}, 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    do_op(vecs[7], lat);
    chk("post_reset_latency", 64'(lat), 64'd4);
    chk("post_reset_res", {44'd0, sum, cout, ovf, zr, ng},
        {44'd0, vecs[7].sum, vecs[7].cout, vecs[7].ovf, vecs[7].zr, vecs[7].ng});
  endtask

  task automatic sweep();
    res_t qw[$];
    res_t qn[$];
    res_t e;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      s_in_valid  = (c < 380) && ($urandom_range(0, 3) != 0);
      s_out_ready = (c >= 380) || ($urandom_range(0, 3) != 0);
      s_sub = 1'($urandom_range(0, 1));
      s_cin = 1'($urandom_range(0, 1));
      w_a = $urandom; w_b = $urandom;
      n_a = 16'($urandom); n_b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: begin w_b = w_a; n_b = n_a; end
        1: begin w_a = 32'h7FFF_FFFF; n_a = 16'h7FFF; end
        2: begin w_a = 32'h8000_0000; n_a = 16'h8000; end
        default: ;
      endcase
      @(negedge clk);
      if (s_in_valid && w_in_ready) qw.push_back(ref_model(32, {32'd0, w_a}, {32'd0, w_b}, s_sub, s_cin));
      if (s_in_valid && n_in_ready) qn.push_back(ref_model(16, {48'd0, n_a}, {48'd0, n_b}, s_sub, s_cin));
      if (w_out_valid && s_out_ready) begin
        if (qw.size() == 0) begin
          checks++; errors++;
          $display("FAIL w32_spurious: got an unexpected result 0x%0h, expected none", w_sum);
        end else begin
          e = qw.pop_front();
          chk("w32_res", {28'd0, w_sum, w_cout, w_ovf, w_zr, w_ng},
              {28'd0, e.sum[31:0], e.cout, e.ovf, e.zr, e.ng});
        end
      end
      if (n_out_valid && s_out_ready) begin
        if (qn.size() == 0) begin
          checks++; errors++;
          $display("FAIL n16_spurious: got an unexpected result 0x%0h, expected none", n_sum);
        end else begin
          e = qn.pop_front();
          chk("n16_res", {44'd0, n_sum, n_cout, n_ovf, n_zr, n_ng},
              {44'd0, e.sum[15:0], e.cout, e.ovf, e.zr, e.ng});
        end
      end
    end
    chk("w32_drained", 64'(qw.size()), 64'd0);
    chk("n16_drained", 64'(qn.size()), 64'd0);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_sub = 1'b0; s_cin = 1'b0;
    w_a = '0; w_b = '0; n_a = '0; n_b = '0;

    //            a         b         sub   cin   sum                          cout  ovf   zr                ng
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100,                     1'b0, 1'b0, 1'b0,             1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000,    1'b0, 1'b1, 1'b0,             !SAT};
    vecs[2] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000,                     1'b1, 1'b0, 1'b1,             1'b0};
    vecs[3] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE,                     1'b0, 1'b0, 1'b0,             1'b1};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000,                     1'b1, 1'b0, 1'b1,             1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000,    1'b1, 1'b1, !SAT,             SAT};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, SAT ? 16'h8000 : 16'h7FFF,    1'b1, 1'b1, 1'b0,             SAT};
    vecs[7] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556,                     1'b0, 1'b0, 1'b0,             1'b0};
    vecs[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F,                     1'b1, 1'b0, 1'b0,             1'b0};
    vecs[9] = '{16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 16'h0000,                     1'b1, 1'b0, 1'b1,             1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {43'd0, out_valid, sum, cout, ovf, zr, ng}, 64'd0);
    reset = 1'b0;
    #1;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i], lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_result", i), {44'd0, sum, cout, ovf, zr, ng},
          {44'd0, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zr, vecs[i].ng});
    end

    stall_test();
    reset_test();
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
